// File: rtl/acumulador_somsub_if.sv
// Bundle between the accumulator controller, its command source and the
// 4-bit combinational adder/subtractor unit it drives.
interface acumulador_somsub_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sumsub;
  logic [WIDTH-1:0] s;
  logic             ov;
  logic [WIDTH-1:0] acc;
  logic             last_ov;
  logic             ov_flag;
  logic             res_valid;

  // The controller is the slave: it takes commands and the unit's result.
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, s, ov,
    output cmd_ready, a, b, sumsub, acc, last_ov, ov_flag, res_valid
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, s, ov,
    input  cmd_ready, a, b, sumsub, acc, last_ov, ov_flag, res_valid
  );
endinterface

// File: rtl/acumulador_somsub.sv
// Accumulator controller wrapped around an external combinational add/sub unit:
// LOAD/CLEAR complete in one cycle, ADD/SUB spend one EXEC cycle on the unit.
module acumulador_somsub #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input logic           clk,
  input logic           rst,
  acumulador_somsub_if.slave bus
);

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sumsub_q, sumsub_d;
  logic             last_ov_q, last_ov_d;
  logic             ov_flag_q, ov_flag_d;
  logic             res_valid_q, res_valid_d;
  logic             accept;

  assign bus.cmd_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      b_q         <= '0;
      sumsub_q    <= 1'b0;
      last_ov_q   <= 1'b0;
      ov_flag_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      sumsub_q    <= sumsub_d;
      last_ov_q   <= last_ov_d;
      ov_flag_q   <= ov_flag_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    b_d         = b_q;
    sumsub_d    = sumsub_q;
    last_ov_d   = last_ov_q;
    ov_flag_d   = ov_flag_q;
    res_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_LOAD: begin
              acc_d       = bus.cmd_data;
              last_ov_d   = 1'b0;
              ov_flag_d   = 1'b0;
              res_valid_d = 1'b1;
            end
            OP_CLEAR: begin
              acc_d       = '0;
              last_ov_d   = 1'b0;
              ov_flag_d   = 1'b0;
              res_valid_d = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              b_d      = bus.cmd_data;
              sumsub_d = bus.cmd_op[1];
              state_d  = EXEC;
            end
            default: ;
          endcase
        end
      end

      EXEC: begin
        // On overflow the wrapped sign bit is inverted, so s[MSB]=1 means the true result was positive.
        if (SATURATE && bus.ov)
          acc_d = bus.s[WIDTH-1] ? SAT_MAX : SAT_MIN;
        else
          acc_d = bus.s;
        last_ov_d   = bus.ov;
        ov_flag_d   = ov_flag_q | bus.ov;
        res_valid_d = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.a         = acc_q;
  assign bus.b         = b_q;
  assign bus.sumsub    = sumsub_q;
  assign bus.acc       = acc_q;
  assign bus.last_ov   = last_ov_q;
  assign bus.ov_flag   = ov_flag_q;
  assign bus.res_valid = res_valid_q;

endmodule

// File: tb/tb_acumulador_somsub.sv
// Directed bench: one wrapping and one saturating instance driven with the same
// commands, each attached to a behavioural 4-bit adder/subtractor.
module tb_acumulador_somsub;

  localparam int W = 4;

  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] ADD   = 2'b01;
  localparam logic [1:0] SUB   = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  acumulador_somsub_if #(.WIDTH(W)) bus0 ();
  acumulador_somsub_if #(.WIDTH(W)) bus1 ();

  acumulador_somsub #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  acumulador_somsub #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic calc_ov(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W-1:0] r, input logic sub);
    if (sub) return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else     return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Stand-in for the external add/sub unit on each instance.
  assign bus0.s  = bus0.sumsub ? bus0.a - bus0.b : bus0.a + bus0.b;
  assign bus0.ov = calc_ov(bus0.a, bus0.b, bus0.s, bus0.sumsub);
  assign bus1.s  = bus1.sumsub ? bus1.a - bus1.b : bus1.a + bus1.b;
  assign bus1.ov = calc_ov(bus1.a, bus1.b, bus1.s, bus1.sumsub);

  task automatic applyStimulus(input logic valid, input logic [1:0] op, input logic [W-1:0] data);
    bus0.cmd_valid = valid;
    bus0.cmd_op    = op;
    bus0.cmd_data  = data;
    bus1.cmd_valid = valid;
    bus1.cmd_op    = op;
    bus1.cmd_data  = data;
    #1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Completion checks for both instances; acc/last_ov may differ between them.
  task automatic checkResult(input string tag,
                             input logic [W-1:0] acc0, input logic lov0,
                             input logic [W-1:0] acc1, input logic lov1,
                             input logic flag);
    checkOutput({tag, " wrap res_valid"}, {7'd0, bus0.res_valid}, 8'd1);
    checkOutput({tag, " wrap acc"},       {4'd0, bus0.acc},       {4'd0, acc0});
    checkOutput({tag, " wrap last_ov"},   {7'd0, bus0.last_ov},   {7'd0, lov0});
    checkOutput({tag, " wrap ov_flag"},   {7'd0, bus0.ov_flag},   {7'd0, flag});
    checkOutput({tag, " sat res_valid"},  {7'd0, bus1.res_valid}, 8'd1);
    checkOutput({tag, " sat acc"},        {4'd0, bus1.acc},       {4'd0, acc1});
    checkOutput({tag, " sat last_ov"},    {7'd0, bus1.last_ov},   {7'd0, lov1});
    checkOutput({tag, " sat ov_flag"},    {7'd0, bus1.ov_flag},   {7'd0, flag});
  endtask

  task automatic doLoadClear(input string tag, input logic [1:0] op, input logic [W-1:0] data);
    applyStimulus(1'b1, op, data);
    checkOutput({tag, " ready"}, {7'd0, bus0.cmd_ready}, 8'd1);
    cycle();
    applyStimulus(1'b0, LOAD, '0);
    checkResult(tag, (op == CLEAR) ? 4'd0 : data, 1'b0, (op == CLEAR) ? 4'd0 : data, 1'b0, 1'b0);
  endtask

  task automatic doArith(input string tag, input logic [1:0] op, input logic [W-1:0] data,
                         input logic [W-1:0] acc0, input logic lov0,
                         input logic [W-1:0] acc1, input logic lov1,
                         input logic flag0, input logic flag1);
    applyStimulus(1'b1, op, data);
    cycle();
    applyStimulus(1'b0, LOAD, '0);
    checkOutput({tag, " exec b"},         {4'd0, bus0.b},          {4'd0, data});
    checkOutput({tag, " exec sumsub"},    {7'd0, bus0.sumsub},     {7'd0, op == SUB});
    checkOutput({tag, " exec ready"},     {7'd0, bus0.cmd_ready},  8'd0);
    checkOutput({tag, " exec res_valid"}, {7'd0, bus1.res_valid},  8'd0);
    cycle();
    checkOutput({tag, " wrap acc"},     {4'd0, bus0.acc},     {4'd0, acc0});
    checkOutput({tag, " wrap last_ov"}, {7'd0, bus0.last_ov}, {7'd0, lov0});
    checkOutput({tag, " wrap ov_flag"}, {7'd0, bus0.ov_flag}, {7'd0, flag0});
    checkOutput({tag, " wrap res_valid"}, {7'd0, bus0.res_valid}, 8'd1);
    checkOutput({tag, " sat acc"},      {4'd0, bus1.acc},     {4'd0, acc1});
    checkOutput({tag, " sat last_ov"},  {7'd0, bus1.last_ov}, {7'd0, lov1});
    checkOutput({tag, " sat ov_flag"},  {7'd0, bus1.ov_flag}, {7'd0, flag1});
    checkOutput({tag, " sat res_valid"}, {7'd0, bus1.res_valid}, 8'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(1'b0, LOAD, '0);
    cycle();
    cycle();

    // Reset state
    checkOutput("rst acc",       {4'd0, bus0.acc},       8'd0);
    checkOutput("rst a",         {4'd0, bus1.a},         8'd0);
    checkOutput("rst b",         {4'd0, bus0.b},         8'd0);
    checkOutput("rst sumsub",    {7'd0, bus0.sumsub},    8'd0);
    checkOutput("rst last_ov",   {7'd0, bus1.last_ov},   8'd0);
    checkOutput("rst ov_flag",   {7'd0, bus1.ov_flag},   8'd0);
    checkOutput("rst res_valid", {7'd0, bus0.res_valid}, 8'd0);
    checkOutput("rst ready",     {7'd0, bus0.cmd_ready}, 8'd0);
    rst = 1'b0;
    #1;
    checkOutput("post-rst ready", {7'd0, bus0.cmd_ready}, 8'd1);

    // LOAD 0011: one-cycle strobe, ready stays high
    doLoadClear("load3", LOAD, 4'b0011);
    checkOutput("load3 ready after", {7'd0, bus0.cmd_ready}, 8'd1);
    cycle();
    checkOutput("load3 strobe drop", {7'd0, bus0.res_valid}, 8'd0);
    checkOutput("load3 acc hold",    {4'd0, bus0.acc},       8'h03);

    // LOAD 0101, ADD 0010 -> 0111
    doLoadClear("load5", LOAD, 4'b0101);
    applyStimulus(1'b1, ADD, 4'b0010);
    cycle();
    applyStimulus(1'b0, LOAD, '0);
    checkOutput("add2 exec a", {4'd0, bus0.a}, 8'h05);
    cycle();
    cycle();
    doLoadClear("load5b", LOAD, 4'b0101);
    doArith("add2", ADD, 4'b0010, 4'b0111, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0);

    // Positive overflow, then recovery (wrap) or re-saturation (sat), then CLEAR
    doLoadClear("load7", LOAD, 4'b0111);
    doArith("add1 ovf",  ADD, 4'b0001, 4'b1000, 1'b1, 4'b0111, 1'b1, 1'b1, 1'b1);
    doArith("add1 next", ADD, 4'b0001, 4'b1001, 1'b0, 4'b0111, 1'b1, 1'b1, 1'b1);
    doLoadClear("clear", CLEAR, 4'b1111);

    // Negative overflow and the -8 minus -8 corner
    doLoadClear("load8", LOAD, 4'b1000);
    doArith("sub1 ovf", SUB, 4'b0001, 4'b0111, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b1);
    doLoadClear("load8b", LOAD, 4'b1000);
    doArith("sub8", SUB, 4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Back-to-back ADD 0001 with cmd_valid held high
    doLoadClear("clear2", CLEAR, 4'b0000);
    applyStimulus(1'b1, ADD, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      checkOutput("b2b accept ready", {7'd0, bus0.cmd_ready}, 8'd1);
      cycle();
      checkOutput("b2b exec ready",     {7'd0, bus0.cmd_ready}, 8'd0);
      checkOutput("b2b exec res_valid", {7'd0, bus0.res_valid}, 8'd0);
      checkOutput("b2b exec acc",       {4'd0, bus0.acc},       8'(i));
      cycle();
      checkOutput("b2b res_valid", {7'd0, bus0.res_valid}, 8'd1);
      checkOutput("b2b wrap acc",  {4'd0, bus0.acc},       8'(i + 1));
      checkOutput("b2b sat acc",   {4'd0, bus1.acc},       8'(i + 1));
    end
    applyStimulus(1'b0, LOAD, '0);

    // Reset during EXEC of ADD 0011 from 0100; reset also beats a pending LOAD
    applyStimulus(1'b1, ADD, 4'b0011);
    cycle();
    checkOutput("abort exec b", {4'd0, bus0.b}, 8'h03);
    rst = 1'b1;
    applyStimulus(1'b1, LOAD, 4'b0110);
    checkOutput("abort ready in rst", {7'd0, bus0.cmd_ready}, 8'd0);
    cycle();
    checkOutput("abort acc",       {4'd0, bus0.acc},       8'd0);
    checkOutput("abort sat acc",   {4'd0, bus1.acc},       8'd0);
    checkOutput("abort b",         {4'd0, bus0.b},         8'd0);
    checkOutput("abort sumsub",    {7'd0, bus0.sumsub},    8'd0);
    checkOutput("abort res_valid", {7'd0, bus0.res_valid}, 8'd0);
    checkOutput("abort ready",     {7'd0, bus0.cmd_ready}, 8'd0);
    rst = 1'b0;
    applyStimulus(1'b0, LOAD, '0);
    checkOutput("abort ready after", {7'd0, bus0.cmd_ready}, 8'd1);
    cycle();
    checkOutput("abort no strobe", {7'd0, bus0.res_valid}, 8'd0);
    checkOutput("abort acc stays", {4'd0, bus0.acc},       8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/acumulador_somsub.md
# acumulador_somsub

Sequential accumulator controller that drives the team's 4-bit combinational adder/subtractor unit. It sits directly upstream and downstream of that unit: it accepts operation commands over a valid/ready handshake and presents registered operands and a mode bit to the unit. It then captures the unit's sum and overflow back into an accumulator register and reports completion with a one-cycle result strobe.

## Interface
- WIDTH, 4, data width; must equal the add/sub unit width (fixed 4)
- SATURATE, 0, 1 = clamp accumulator to signed max/min on overflow; 0 = keep wrapped result

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
- cmd_data  in  WIDTH  operand (two's complement)
- a  out  WIDTH  to add/sub unit; equals acc
- b  out  WIDTH  to add/sub unit; registered operand
- sumsub  out  1  to add/sub unit; 0 add, 1 subtract (registered)
- s  in  WIDTH  from add/sub unit, result
- ov  in  1  from add/sub unit, signed overflow
- acc  out  WIDTH  accumulator value
- last_ov  out  1  overflow of most recent ADD/SUB (cleared by LOAD/CLEAR)
- ov_flag  out  1  sticky overflow; OR of all ADD/SUB overflows since last LOAD/CLEAR
- res_valid  out  1  one-cycle pulse: acc/last_ov/ov_flag updated by a completed command

## Operation
- States: IDLE, EXEC.
- cmd_ready = (state == IDLE) && !rst. A command is accepted on any cycle where cmd_valid && cmd_ready.
- In IDLE, on accept:
  - LOAD: acc <= cmd_data; last_ov <= 0; ov_flag <= 0; stay IDLE; res_valid <= 1.
  - CLEAR: acc <= 0; last_ov <= 0; ov_flag <= 0; stay IDLE; res_valid <= 1.
  - ADD/SUB: b <= cmd_data; sumsub <= cmd_op[1] (ADD 0, SUB 1); go to EXEC; acc unchanged.
- In EXEC (one cycle, cmd_ready = 0), the unit sees stable a/b/sumsub:
  - acc <= s when SATURATE = 0 or ov = 0.
  - Otherwise acc <= 0111 if s[MSB] = 1 (true result positive), or 1000 if s[MSB] = 0.
  - last_ov <= ov; ov_flag <= ov_flag | ov; res_valid <= 1; go to IDLE.
- res_valid is 0 on every cycle it is not explicitly set.
- cmd_op/cmd_data are ignored when not accepted. A command held across EXEC is consumed only when back in IDLE.
- Arithmetic is modulo 2^WIDTH two's complement. No carry-out is exposed.

## Timing
- Reset (rst high at an edge): state IDLE; acc = 0, b = 0, sumsub = 0, last_ov = 0, ov_flag = 0, res_valid = 0. a follows acc, so a = 0. cmd_ready is 0 while rst is high.
- Reset mid-EXEC: the operation is aborted, no capture, no res_valid. Reset wins over any simultaneous accept.
- LOAD/CLEAR accepted in cycle t: acc updated at the end of t; res_valid = 1 in t+1; cmd_ready = 1 in t+1. Throughput is 1 per cycle.
- ADD/SUB accepted in cycle t: b/sumsub valid in t+1 (EXEC, cmd_ready = 0); acc/flags updated at the end of t+1; res_valid = 1 in t+2, with the new acc visible in the same cycle. The next accept is possible in t+2. Throughput is 1 per 2 cycles.
- The add/sub path is combinational from registered a/b/sumsub to s/ov and must settle within one clock period.

## Test plan
- Reset, then LOAD 0011: acc = 0011, res_valid high exactly one cycle after accept, ov_flag = 0, cmd_ready high throughout.
- LOAD 0101, then ADD 0010: in EXEC a = 0101, b = 0010, sumsub = 0, cmd_ready = 0. Two cycles after accept acc = 0111, res_valid = 1, last_ov = 0.
- SATURATE = 0: LOAD 0111, ADD 0001 -> acc = 1000, last_ov = 1, ov_flag = 1. Then ADD 0001 -> acc = 1001, last_ov = 0, ov_flag stays 1. Then CLEAR -> acc = 0000, ov_flag = 0.
- SATURATE = 1: LOAD 0111, ADD 0001 -> acc = 0111, ov_flag = 1. LOAD 1000, SUB 0001 -> acc = 1000, last_ov = 1. LOAD 1000, SUB 1000 -> acc = 0000, last_ov = 0.
- Back-to-back: cmd_valid held high with ADD 0001 on four consecutive accepts from acc = 0000. Required: accepts spaced 2 cycles apart, acc = 0001/0010/0011/0100, four res_valid pulses, none during EXEC.
- rst asserted during EXEC of ADD 0011 from acc = 0100: the next cycle has acc = 0, b = 0, sumsub = 0, res_valid = 0, cmd_ready = 0 while rst is high, then 1.
